mux_fb: RTL and testbench
=========================

# mux_fb

Operand-B forwarding multiplexer for the 16-bit pipelined datapath, placed in the EX stage ahead of the ALU B input. It selects between the ID/EX-latched operand 2 and the forwarded results from the EX/MEM and MEM/WB pipeline registers under control of the 2-bit ForwardB code from the forwarding unit. The selected operand is driven combinationally. The block also provides a registered copy of the selected operand, per-source forwarding event counters and a sticky illegal-select flag for debug and performance monitoring.

## Interface
- WIDTH, 16, data width of all operand ports and of MUXFB_out / MUXFB_out_q
- CNT_WIDTH, 16, width of the forwarding event counters
- clk  input  1  rising-edge clock for all registered state
- rst  input  1  asynchronous, active-low reset
- ForwardB  input  2  forwarding select from the forwarding unit
- IDEX_op2  input  WIDTH  operand 2 from the ID/EX register (no forwarding)
- EM_op2  input  WIDTH  result forwarded from the EX/MEM register
- MWB_op2  input  WIDTH  result forwarded from the MEM/WB register
- en  input  1  pipeline advance; gates all registered updates
- MUXFB_out  output  WIDTH  selected operand B, combinational
- MUXFB_out_q  output  WIDTH  MUXFB_out registered on clk when en=1
- em_fwd_cnt  output  CNT_WIDTH  count of EX/MEM forwards
- mwb_fwd_cnt  output  CNT_WIDTH  count of MEM/WB forwards
- illegal_sel  output  1  sticky flag: ForwardB=2'b11 seen while en=1

## Operation
- Select decode, purely combinational, no clock involvement:
  - ForwardB=2'b00 -> MUXFB_out = IDEX_op2
  - ForwardB=2'b10 -> MUXFB_out = EM_op2
  - ForwardB=2'b01 -> MUXFB_out = MWB_op2
  - ForwardB=2'b11 -> MUXFB_out = IDEX_op2 (treated as no-forward)
  - ForwardB containing X/Z -> MUXFB_out = IDEX_op2 in synthesis; X is acceptable in simulation.
- Registered path, updated on rising clk only when en=1; all registers hold when en=0:
  - MUXFB_out_q <= MUXFB_out
  - em_fwd_cnt increments by 1 when ForwardB=2'b10
  - mwb_fwd_cnt increments by 1 when ForwardB=2'b01
  - Both counters saturate at all-ones and never wrap.
  - illegal_sel <= 1 when ForwardB=2'b11. It stays 1 until reset.
- No other side effects. Input data values never affect the counters or the flag.

## Timing
- MUXFB_out has zero-cycle latency and follows any change on ForwardB or the operand inputs within the same delta or cycle.
- MUXFB_out_q, counters and illegal_sel have 1-cycle latency: they reflect the inputs sampled at the rising clk edge where en=1.
- Reset (rst=0) is asynchronous:
  - MUXFB_out_q=0, em_fwd_cnt=0, mwb_fwd_cnt=0 and illegal_sel=0 immediately, independent of clk.
  - MUXFB_out stays combinational and valid during reset.
- Reset asserted mid-operation clears state without waiting for a clock edge.
- Reset release is synchronised by the design that uses the block. The first update occurs on the first rising clk edge with rst=1 and en=1.
- If rst and a clk edge coincide, reset wins.

## Test plan
- Combinational select, no clock needed: IDEX_op2=0x000D, EM_op2=0x000A, MWB_op2=0x0006.
  - ForwardB=00 -> MUXFB_out=0x000D
  - ForwardB=10 -> MUXFB_out=0x000A
  - ForwardB=01 -> MUXFB_out=0x0006
  - ForwardB=11 -> MUXFB_out=0x000D
- Registered copy: en=1, ForwardB=10, EM_op2=0xBEEF, one clk edge -> MUXFB_out_q=0xBEEF. Then en=0 and change inputs -> MUXFB_out_q holds 0xBEEF.
- Counters: en=1, ForwardB sequence 10,10,01,00,11 over 5 clocks -> em_fwd_cnt=2, mwb_fwd_cnt=1, illegal_sel=1.
- Saturation: drive 2^CNT_WIDTH+3 cycles of ForwardB=10 with en=1 -> em_fwd_cnt=0xFFFF; mwb_fwd_cnt unchanged.
- Asynchronous reset: with non-zero state, pulse rst=0 between clk edges -> all registered outputs 0 immediately. MUXFB_out still tracks the select throughout.
- X/changing data: toggle EM_op2 while ForwardB=00 -> MUXFB_out is unaffected and equals IDEX_op2.

Source files
------------

// File: rtl/mux_fb.sv
`default_nettype none
// ============================================================================
// Module      : mux_fb
// Description : EX-stage operand-B forwarding mux with a registered copy,
//               per-source forwarding counters and a sticky illegal-select flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_fb #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           ForwardB,
    input  logic [WIDTH-1:0]     IDEX_op2,
    input  logic [WIDTH-1:0]     EM_op2,
    input  logic [WIDTH-1:0]     MWB_op2,
    input  logic                 en,
    output logic [WIDTH-1:0]     MUXFB_out,
    output logic [WIDTH-1:0]     MUXFB_out_q,
    output logic [CNT_WIDTH-1:0] em_fwd_cnt,
    output logic [CNT_WIDTH-1:0] mwb_fwd_cnt,
    output logic                 illegal_sel
);

    localparam logic [1:0]           c_SEL_IDEX = 2'b00;
    localparam logic [1:0]           c_SEL_MWB  = 2'b01;
    localparam logic [1:0]           c_SEL_EM   = 2'b10;
    localparam logic [1:0]           c_SEL_ILL  = 2'b11;
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]     w_sel;
    logic [WIDTH-1:0]     r_out_q;
    logic [CNT_WIDTH-1:0] r_em_cnt;
    logic [CNT_WIDTH-1:0] r_mwb_cnt;
    logic                 r_illegal;

    // Unused code 11 and any unknown select fall back to the unforwarded operand.
    always_comb begin
        w_sel = IDEX_op2;
        case (ForwardB)
            c_SEL_EM:   w_sel = EM_op2;
            c_SEL_MWB:  w_sel = MWB_op2;
            c_SEL_IDEX: w_sel = IDEX_op2;
            default:    w_sel = IDEX_op2;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_q   <= '0;
            r_em_cnt  <= '0;
            r_mwb_cnt <= '0;
            r_illegal <= 1'b0;
        end else if (en) begin
            r_out_q <= w_sel;
            if (ForwardB == c_SEL_EM && r_em_cnt != c_CNT_MAX)
                r_em_cnt <= r_em_cnt + c_CNT_ONE;
            if (ForwardB == c_SEL_MWB && r_mwb_cnt != c_CNT_MAX)
                r_mwb_cnt <= r_mwb_cnt + c_CNT_ONE;
            if (ForwardB == c_SEL_ILL)
                r_illegal <= 1'b1;
        end
    end

    assign MUXFB_out   = w_sel;
    assign MUXFB_out_q = r_out_q;
    assign em_fwd_cnt  = r_em_cnt;
    assign mwb_fwd_cnt = r_mwb_cnt;
    assign illegal_sel = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_mux_fb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_fb
// Description : Directed self-checking bench for mux_fb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_fb;

    localparam int WIDTH     = 16;
    localparam int CNT_WIDTH = 16;

    logic                 clk;
    logic                 rst;
    logic [1:0]           ForwardB;
    logic [WIDTH-1:0]     IDEX_op2;
    logic [WIDTH-1:0]     EM_op2;
    logic [WIDTH-1:0]     MWB_op2;
    logic                 en;
    logic [WIDTH-1:0]     MUXFB_out;
    logic [WIDTH-1:0]     MUXFB_out_q;
    logic [CNT_WIDTH-1:0] em_fwd_cnt;
    logic [CNT_WIDTH-1:0] mwb_fwd_cnt;
    logic                 illegal_sel;

    int checks = 0;
    int errors = 0;

    mux_fb #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .ForwardB    (ForwardB),
        .IDEX_op2    (IDEX_op2),
        .EM_op2      (EM_op2),
        .MWB_op2     (MWB_op2),
        .en          (en),
        .MUXFB_out   (MUXFB_out),
        .MUXFB_out_q (MUXFB_out_q),
        .em_fwd_cnt  (em_fwd_cnt),
        .mwb_fwd_cnt (mwb_fwd_cnt),
        .illegal_sel (illegal_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b0;
        en       = 1'b0;
        ForwardB = 2'b00;
        IDEX_op2 = 16'h000D;
        EM_op2   = 16'h000A;
        MWB_op2  = 16'h0006;
        #2;

        // reset state
        check("rst_out_q",   32'(MUXFB_out_q), 32'h0);
        check("rst_em_cnt",  32'(em_fwd_cnt),  32'h0);
        check("rst_mwb_cnt", 32'(mwb_fwd_cnt), 32'h0);
        check("rst_illegal", 32'(illegal_sel), 32'h0);

        // combinational select, valid even while reset is held
        ForwardB = 2'b00; #1; check("sel_00", 32'(MUXFB_out), 32'h000D);
        ForwardB = 2'b10; #1; check("sel_10", 32'(MUXFB_out), 32'h000A);
        ForwardB = 2'b01; #1; check("sel_01", 32'(MUXFB_out), 32'h0006);
        ForwardB = 2'b11; #1; check("sel_11", 32'(MUXFB_out), 32'h000D);

        @(negedge clk);
        rst = 1'b1;

        // registered copy and hold
        en = 1'b1; ForwardB = 2'b10; EM_op2 = 16'hBEEF;
        tick();
        check("reg_q",      32'(MUXFB_out_q), 32'hBEEF);
        check("reg_em_cnt", 32'(em_fwd_cnt),  32'h1);
        en = 1'b0; ForwardB = 2'b01; MWB_op2 = 16'h1234; EM_op2 = 16'h5555;
        tick();
        tick();
        check("hold_q",       32'(MUXFB_out_q), 32'hBEEF);
        check("hold_mwb_cnt", 32'(mwb_fwd_cnt), 32'h0);
        check("hold_em_cnt",  32'(em_fwd_cnt),  32'h1);

        // asynchronous reset between edges
        #2;
        rst = 1'b0;
        #1;
        check("arst_q",      32'(MUXFB_out_q), 32'h0);
        check("arst_em_cnt", 32'(em_fwd_cnt),  32'h0);
        check("arst_out",    32'(MUXFB_out),   32'h1234);
        ForwardB = 2'b10; #1;
        check("arst_track",  32'(MUXFB_out),   32'h5555);
        rst = 1'b1;

        // counter sequence 10,10,01,00,11
        en = 1'b1;
        ForwardB = 2'b10; tick();
        ForwardB = 2'b10; tick();
        ForwardB = 2'b01; tick();
        ForwardB = 2'b00; tick();
        ForwardB = 2'b11; tick();
        check("seq_em_cnt",  32'(em_fwd_cnt),  32'h2);
        check("seq_mwb_cnt", 32'(mwb_fwd_cnt), 32'h1);
        check("seq_illegal", 32'(illegal_sel), 32'h1);
        check("seq_q",       32'(MUXFB_out_q), 32'h000D);

        // saturation: 65532 + 1 + 6 = 2^16+3 cycles of ForwardB=10
        ForwardB = 2'b10;
        repeat (65532) @(posedge clk);
        #1;
        check("sat_em_fffe", 32'(em_fwd_cnt),  32'hFFFE);
        tick();
        check("sat_em_ffff", 32'(em_fwd_cnt),  32'hFFFF);
        repeat (6) tick();
        check("sat_em_hold", 32'(em_fwd_cnt),  32'hFFFF);
        check("sat_mwb",     32'(mwb_fwd_cnt), 32'h1);
        check("sat_illegal", 32'(illegal_sel), 32'h1);

        // data toggling on an unselected input
        ForwardB = 2'b00;
        EM_op2 = 16'h0000; #1; check("tog_0", 32'(MUXFB_out), 32'h000D);
        EM_op2 = 16'hFFFF; #1; check("tog_1", 32'(MUXFB_out), 32'h000D);
        EM_op2 = 16'hA5A5; #1; check("tog_2", 32'(MUXFB_out), 32'h000D);

        // final asynchronous reset clears the sticky flag and saturated counter
        #1;
        rst = 1'b0;
        #1;
        check("arst2_illegal", 32'(illegal_sel), 32'h0);
        check("arst2_em_cnt",  32'(em_fwd_cnt),  32'h0);
        check("arst2_mwb_cnt", 32'(mwb_fwd_cnt), 32'h0);
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
